// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   CNT_W_DEF   : default counter/divisor width
//   DEF_DIV_DEF : default divisor loaded at reset
//   div_cfg_t   : divisor/high-time pair, held at CFG_W bits
//   clamp_cfg() : sanitises a requested (div, hi) pair so that the divided
//                 clock always toggles: div >= 2 and 1 <= hi <= div-1.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int DEF_DIV_DEF = 10;

  // Working width of the clamp. Channels zero-extend into it, so CNT_W must
  // not exceed it.
  localparam int CFG_W = 32;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] hi;
  } div_cfg_t;

  // The high time is clamped against the already-clamped divisor.
  function automatic div_cfg_t clamp_cfg(input logic [CFG_W-1:0] div,
                                         input logic [CFG_W-1:0] hi);
    div_cfg_t r;
    r.div = (div < CFG_W'(2)) ? CFG_W'(2) : div;
    r.hi  = (hi == '0) ? CFG_W'(1) : hi;
    if (r.hi >= r.div) begin
      r.hi = r.div - CFG_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow settings, pending flag and the
// registered divided clock plus period-start tick.
//   clk_i     : system clock, rising edge
//   rst_ni    : async active-low reset
//   en_i      : channel enable (level)
//   load_i    : 1-cycle strobe, capture div_i/hi_i into the shadow
//   div_i     : requested divisor
//   hi_i      : requested high time in clk_i cycles
//   clk_o     : divided clock, registered
//   tick_o    : 1-cycle pulse coincident with each clk_o rise
//   pending_o : captured settings not yet active
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] hi_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(DEF_DIV / 2);

  logic [CNT_W-1:0] adiv_q, adiv_d;
  logic [CNT_W-1:0] ahi_q, ahi_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] shi_q, shi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  div_cfg_t         cap;
  logic [CNT_W-1:0] cap_div;
  logic [CNT_W-1:0] cap_hi;
  logic             wrap;
  logic             apply;

  always_comb begin
    cap     = clamp_cfg(CFG_W'(div_i), CFG_W'(hi_i));
    cap_div = CNT_W'(cap.div);
    cap_hi  = CNT_W'(cap.hi);
  end

  // Settings only change at a period boundary or while the channel is idle,
  // which is what keeps reprogramming glitch-free.
  assign wrap  = (cnt_q == adiv_q - CNT_W'(1));
  assign apply = !en_i || wrap;

  always_comb begin
    sdiv_d = sdiv_q;
    shi_d  = shi_q;
    adiv_d = adiv_q;
    ahi_d  = ahi_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;

    if (load_i) begin
      sdiv_d = cap_div;
      shi_d  = cap_hi;
      pend_d = 1'b1;
    end

    // Uses the post-load shadow so a load on the apply edge takes effect
    // immediately and never leaves pending set.
    if (apply) begin
      adiv_d = sdiv_d;
      ahi_d  = shi_d;
      pend_d = 1'b0;
    end

    if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      clk_d  = (cnt_d < ahi_d);
      tick_d = (cnt_d == '0);
    end else begin
      // Park one before wrap so the first enabled edge starts a full period.
      cnt_d = adiv_d - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adiv_q <= RST_DIV;
      ahi_q  <= RST_HI;
      sdiv_q <= RST_DIV;
      shi_q  <= RST_HI;
      cnt_q  <= RST_DIV - CNT_W'(1);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      adiv_q <= adiv_d;
      ahi_q  <= ahi_d;
      sdiv_q <= sdiv_d;
      shi_q  <= shi_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider. Each channel is an
// independent clk_div_ch; this level only unpacks the per-channel buses.
//   clk_in  : system clock, rising edge
//   reset_n : async active-low reset
//   en      : per-channel enable
//   load    : per-channel capture strobe for div_val/hi_val
//   div_val : divisors, channel c at [c*CNT_W +: CNT_W]
//   hi_val  : high times, same packing
//   clk_out : divided clocks, registered
//   tick    : period-start pulses
//   pending : per-channel captured-but-not-active flag
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH*CNT_W-1:0] div_val,
  input  logic [N_CH*CNT_W-1:0] hi_val,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       pending
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i     (clk_in),
      .rst_ni    (reset_n),
      .en_i      (en[c]),
      .load_i    (load[c]),
      .div_i     (div_val[c*CNT_W +: CNT_W]),
      .hi_i      (hi_val[c*CNT_W +: CNT_W]),
      .clk_o     (clk_out[c]),
      .tick_o    (tick[c]),
      .pending_o (pending[c])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic                  clk_in;
  logic                  reset_n;
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       load;
  logic [N_CH*CNT_W-1:0] div_val;
  logic [N_CH*CNT_W-1:0] hi_val;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pending;

  int n_cmp  = 0;
  int n_fail = 0;

  clk_div_prog #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (10)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (en),
    .load    (load),
    .div_val (div_val),
    .hi_val  (hi_val),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // one rising edge, then sample/drive point on the falling edge
  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input int d, input int h);
    div_val[ch*CNT_W +: CNT_W] = CNT_W'(d);
    hi_val[ch*CNT_W +: CNT_W]  = CNT_W'(h);
  endtask

  // Strobe load for one edge on channel ch.
  task automatic load_ch(input int ch, input int d, input int h);
    set_cfg(ch, d, h);
    load[ch] = 1'b1;
    cyc();
    load[ch] = 1'b0;
  endtask

  // Called at the sample point of a period start; checks whole periods.
  task automatic check_wave(input int ch, input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < hi + lo; i++) begin
        chk($sformatf("wave_clk ch%0d p%0d i%0d", ch, p, i), 32'(clk_out[ch]), 32'(i < hi));
        chk($sformatf("wave_tick ch%0d p%0d i%0d", ch, p, i), 32'(tick[ch]), 32'(i == 0));
        cyc();
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = '0;
    load    = '0;
    div_val = '0;
    hi_val  = '0;
    @(negedge clk_in);
    @(negedge clk_in);

    // reset state
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("idle_clk", 32'(clk_out), 32'h0);

    // 1: defaults, first tick one edge after enable, 5 high / 5 low
    en[0] = 1'b1;
    cyc();
    check_wave(0, 5, 5, 2);

    // 2: load div=4 hi=1 at cnt=3; current 10-cycle period finishes first
    cyc(); cyc(); cyc();
    load_ch(0, 4, 1);
    for (int k = 4; k < 10; k++) begin
      chk($sformatf("t2_pending k%0d", k), 32'(pending[0]), 32'h1);
      chk($sformatf("t2_clk k%0d", k), 32'(clk_out[0]), 32'(k < 5));
      chk($sformatf("t2_tick k%0d", k), 32'(tick[0]), 32'h0);
      cyc();
    end
    chk("t2_pending_clear", 32'(pending[0]), 32'h0);
    check_wave(0, 1, 3, 2);

    // 3: clamping, div=0/hi=0 -> 2/1, then div=6/hi=9 -> 6/5
    load_ch(0, 0, 0);
    chk("t3a_pending", 32'(pending[0]), 32'h1);
    cyc(); cyc(); cyc();
    chk("t3a_pending_clear", 32'(pending[0]), 32'h0);
    check_wave(0, 1, 1, 3);
    load_ch(0, 6, 9);
    cyc();
    check_wave(0, 5, 1, 2);

    // 5: back-to-back loads inside one period, last one wins
    load_ch(0, 8, 4);
    load_ch(0, 3, 1);
    chk("t5_pending", 32'(pending[0]), 32'h1);
    cyc(); cyc(); cyc(); cyc();
    chk("t5_pending_clear", 32'(pending[0]), 32'h0);
    check_wave(0, 1, 2, 2);

    // 4: channel 1 disabled mid-high, load while disabled, re-enable
    en[1] = 1'b1;
    cyc();
    chk("t4_first_clk", 32'(clk_out[1]), 32'h1);
    chk("t4_first_tick", 32'(tick[1]), 32'h1);
    cyc(); cyc();
    chk("t4_high", 32'(clk_out[1]), 32'h1);
    en[1] = 1'b0;
    cyc();
    chk("t4_off_clk", 32'(clk_out[1]), 32'h0);
    chk("t4_off_tick", 32'(tick[1]), 32'h0);
    load_ch(1, 4, 2);
    chk("t4_load_pending", 32'(pending[1]), 32'h0);
    chk("t4_load_clk", 32'(clk_out[1]), 32'h0);
    cyc();
    chk("t4_idle_clk", 32'(clk_out[1]), 32'h0);
    en[1] = 1'b1;
    cyc();
    check_wave(1, 2, 2, 2);

    // 6: all channels 2/3/7/65535, then async reset mid-run
    en = '0;
    cyc();
    set_cfg(0, 2, 1);
    set_cfg(1, 3, 1);
    set_cfg(2, 7, 3);
    set_cfg(3, 65535, 100);
    load = '1;
    cyc();
    load = '0;
    chk("t6_pending_idle", 32'(pending), 32'h0);
    en = '1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6_clk k%0d", k), 32'(clk_out),
          32'({k < 100, (k % 7) < 3, (k % 3) == 0, (k % 2) == 0}));
      chk($sformatf("t6_tick k%0d", k), 32'(tick),
          32'({k == 0, (k % 7) == 0, (k % 3) == 0, (k % 2) == 0}));
      cyc();
    end
    load_ch(3, 5, 2);
    chk("t6_pending3", 32'(pending), 32'h8);
    chk("t6_clk3_high", 32'(clk_out[3]), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_clk", 32'(clk_out), 32'h0);
    chk("t6_async_tick", 32'(tick), 32'h0);
    chk("t6_async_pending", 32'(pending), 32'h0);
    en = 4'b0001;
    @(negedge clk_in);
    chk("t6_held_clk", 32'(clk_out), 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("t6_restart_clk", 32'(clk_out), 32'h1);
    chk("t6_restart_tick", 32'(tick), 32'h1);
    check_wave(0, 5, 5, 1);
    chk("t6_final_pending", 32'(pending), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
